// File: rtl/aq_djpeg_pkg.sv
// Shared constants and types for the JPEG entropy-coded-segment front end.
package aq_djpeg_pkg;

  localparam int unsigned WIN_BITS = 32;

  localparam logic [7:0] MARKER_STUFF = 8'h00;
  localparam logic [7:0] MARKER_FILL  = 8'hFF;
  localparam logic [7:0] RST0         = 8'hD0;
  localparam logic [7:0] RST7         = 8'hD7;
  localparam logic [7:0] EOI          = 8'hD9;

  typedef enum logic [1:0] {
    UNS_IDLE,
    UNS_FF_PEND,
    UNS_HOLD
  } unstuffState_t;

endpackage

// File: rtl/aq_djpeg_unstuff.sv
// Byte-level unstuffer: strips 0xFF00 stuffing and fill bytes, and detects markers.
// After a marker it stalls input until the marker is released.
module aq_djpeg_unstuff
  import aq_djpeg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       dataInit,
  input  logic       byteValid,
  input  logic [7:0] byteIn,
  input  logic       markerRelease,
  output logic       push,
  output logic [7:0] pushData,
  output logic       hold,
  output logic       holdNext,
  output logic       markerEnable,
  output logic [7:0] markerData
);

  unstuffState_t state, nextState;
  logic          isMarker;

  // push is decoded combinationally so an accepted byte lands in the buffer on the same edge
  always_comb begin
    nextState = state;
    push      = 1'b0;
    pushData  = byteIn;
    isMarker  = 1'b0;
    if (byteValid) begin
      case (state)
        UNS_IDLE: begin
          if (byteIn == MARKER_FILL) nextState = UNS_FF_PEND;
          else                       push      = 1'b1;
        end
        UNS_FF_PEND: begin
          if (byteIn == MARKER_STUFF) begin
            push      = 1'b1;
            pushData  = MARKER_FILL;
            nextState = UNS_IDLE;
          end else if (byteIn != MARKER_FILL) begin
            isMarker  = 1'b1;
            nextState = UNS_HOLD;
          end
        end
        default: ;
      endcase
    end
    if (state == UNS_HOLD && markerRelease) nextState = UNS_IDLE;
    if (dataInit) begin
      nextState = UNS_IDLE;
      push      = 1'b0;
      isMarker  = 1'b0;
    end
  end

  assign hold     = (state == UNS_HOLD);
  assign holdNext = (nextState == UNS_HOLD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= UNS_IDLE;
      markerEnable <= 1'b0;
      markerData   <= '0;
    end else begin
      state        <= nextState;
      markerEnable <= isMarker;
      if (dataInit)      markerData <= '0;
      else if (isMarker) markerData <= byteIn;
    end
  end

endmodule

// File: rtl/aq_djpeg_bitstream.sv
// Bit feeder for the Huffman decoder: left-aligned bit buffer fed by unstuffed
// scan bytes, presenting a 32-bit window of the oldest pending bits.
module aq_djpeg_bitstream
  import aq_djpeg_pkg::*;
#(
  parameter int unsigned BUF_BITS = 64
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        DataInit,
  input  logic        ByteInEnable,
  input  logic [7:0]  ByteIn,
  output logic        ByteInRead,
  input  logic        DecodeUseBit,
  input  logic [6:0]  DecodeUseWidth,
  output logic        DataOutEnable,
  output logic [31:0] DataOut,
  output logic        MarkerEnable,
  output logic [7:0]  MarkerData,
  output logic        MarkerHold,
  input  logic        MarkerRelease,
  output logic        Underflow
);

  logic [BUF_BITS-1:0] bitBuf, bitBufNext;
  logic [6:0]          count, countNext, remain, useWidth;
  logic                underflowNext, outEnNext, readyQ;
  logic                byteValid, push, hold, holdNext, markerRel;
  logic [7:0]          pushData;

  // readyQ keeps ByteInRead low while reset is asserted
  assign ByteInRead = readyQ && !DataInit && !hold && (count <= 7'(BUF_BITS - 8));
  assign byteValid  = ByteInEnable && ByteInRead;
  assign useWidth   = DecodeUseBit ? DecodeUseWidth : '0;
  assign markerRel  = MarkerRelease && hold;
  assign remain     = count - useWidth;
  assign DataOut    = bitBuf[BUF_BITS-1 -: WIN_BITS];
  assign MarkerHold = hold;

  aq_djpeg_unstuff unstuff (
    .clk          (clk),
    .rst          (rst),
    .dataInit     (DataInit),
    .byteValid    (byteValid),
    .byteIn       (ByteIn),
    .markerRelease(MarkerRelease),
    .push         (push),
    .pushData     (pushData),
    .hold         (hold),
    .holdNext     (holdNext),
    .markerEnable (MarkerEnable),
    .markerData   (MarkerData)
  );

  always_comb begin
    bitBufNext    = bitBuf;
    countNext     = count;
    underflowNext = Underflow;
    if (DataInit) begin
      bitBufNext    = '0;
      countNext     = '0;
      underflowNext = 1'b0;
    end else if (markerRel) begin
      bitBufNext = '0;
      countNext  = '0;
    end else if (useWidth > count) begin
      bitBufNext    = '0;
      countNext     = '0;
      underflowNext = 1'b1;
    end else begin
      bitBufNext = bitBuf << useWidth;
      if (push)
        bitBufNext = bitBufNext | ({pushData, {(BUF_BITS-8){1'b0}}} >> remain);
      countNext = remain + (push ? 7'd8 : 7'd0);
    end
    outEnNext = (countNext >= 7'(WIN_BITS)) || (holdNext && countNext != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bitBuf        <= '0;
      count         <= '0;
      Underflow     <= 1'b0;
      DataOutEnable <= 1'b0;
      readyQ        <= 1'b0;
    end else begin
      bitBuf        <= bitBufNext;
      count         <= countNext;
      Underflow     <= underflowNext;
      DataOutEnable <= outEnNext;
      readyQ        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aq_djpeg_bitstream.sv
// Directed self-checking bench for aq_djpeg_bitstream.
module tb_aq_djpeg_bitstream;

  logic        rst, clk;
  logic        DataInit, ByteInEnable, ByteInRead, DecodeUseBit;
  logic [7:0]  ByteIn;
  logic [6:0]  DecodeUseWidth;
  logic        DataOutEnable, MarkerEnable, MarkerHold, MarkerRelease, Underflow;
  logic [31:0] DataOut;
  logic [7:0]  MarkerData;

  int unsigned checks = 0;
  int unsigned errors = 0;

  aq_djpeg_bitstream #(.BUF_BITS(64)) dut (
    .rst           (rst),
    .clk           (clk),
    .DataInit      (DataInit),
    .ByteInEnable  (ByteInEnable),
    .ByteIn        (ByteIn),
    .ByteInRead    (ByteInRead),
    .DecodeUseBit  (DecodeUseBit),
    .DecodeUseWidth(DecodeUseWidth),
    .DataOutEnable (DataOutEnable),
    .DataOut       (DataOut),
    .MarkerEnable  (MarkerEnable),
    .MarkerData    (MarkerData),
    .MarkerHold    (MarkerHold),
    .MarkerRelease (MarkerRelease),
    .Underflow     (Underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock with the given inputs, then sample 1ns after the edge
  task automatic cyc(input logic en, input logic [7:0] b, input logic use_, input logic [6:0] w,
                     input logic rel, input logic init);
    ByteInEnable = en; ByteIn = b; DecodeUseBit = use_; DecodeUseWidth = w;
    MarkerRelease = rel; DataInit = init;
    @(posedge clk); #1;
    ByteInEnable = 0; DecodeUseBit = 0; DecodeUseWidth = 0; MarkerRelease = 0; DataInit = 0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    cyc(1, b, 0, 0, 0, 0);
  endtask

  task automatic doInit();
    cyc(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    logic sawMarker;
    rst = 0; DataInit = 0; ByteInEnable = 0; ByteIn = 0;
    DecodeUseBit = 0; DecodeUseWidth = 0; MarkerRelease = 0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_read", ByteInRead, 0);
    checkVal("rst_dout", DataOut, 0);
    checkVal("rst_outs", {DataOutEnable, MarkerEnable, MarkerHold, Underflow, MarkerData}, 0);
    #2 rst = 1;
    @(posedge clk); #1;
    checkVal("rst_rel_read", ByteInRead, 1);

    // plain bytes fill the window
    sendByte(8'h12); sendByte(8'h34); sendByte(8'h56);
    checkVal("t1_en3", DataOutEnable, 0);
    sendByte(8'h78);
    checkVal("t1_en4", DataOutEnable, 1);
    checkVal("t1_dout", DataOut, 32'h12345678);
    checkVal("t1_count", dut.count, 32);

    // consume 4 while pushing 0x9A: byte lands right after the 28 remaining bits
    cyc(1, 8'h9A, 1, 4, 0, 0);
    checkVal("t3_dout", DataOut, 32'h23456789);
    checkVal("t3_count", dut.count, 36);
    cyc(0, 0, 1, 4, 0, 0);
    checkVal("t3_dout2", DataOut, 32'h3456789A);
    checkVal("t3_count2", dut.count, 32);
    doInit();
    checkVal("init_count", dut.count, 0);
    checkVal("init_en", DataOutEnable, 0);

    // stuffed FF00
    sawMarker = 0;
    sendByte(8'hFF); sawMarker |= MarkerEnable;
    checkVal("t2_ffpend_count", dut.count, 0);
    sendByte(8'h00); sawMarker |= MarkerEnable;
    sendByte(8'hAB); sawMarker |= MarkerEnable;
    sendByte(8'hCD); sawMarker |= MarkerEnable;
    sendByte(8'hEF); sawMarker |= MarkerEnable;
    checkVal("t2_dout", DataOut, 32'hFFABCDEF);
    checkVal("t2_nomarker", sawMarker, 0);
    checkVal("t2_count", dut.count, 32);
    doInit();

    // fill bytes FF FF between FF and 00
    sendByte(8'hFF); sendByte(8'hFF); sendByte(8'hFF); sendByte(8'h00);
    checkVal("fill_dout", DataOut, 32'hFF000000);
    checkVal("fill_count", dut.count, 8);
    checkVal("fill_marker", {MarkerEnable, MarkerHold}, 0);
    doInit();

    // marker detection and release
    sendByte(8'hAB); sendByte(8'hFF); sendByte(8'hD3);
    checkVal("mk_pulse", MarkerEnable, 1);
    checkVal("mk_data", MarkerData, 8'hD3);
    checkVal("mk_hold", MarkerHold, 1);
    checkVal("mk_read", ByteInRead, 0);
    checkVal("mk_dout", DataOut, 32'hAB000000);
    checkVal("mk_en", DataOutEnable, 1);
    cyc(1, 8'h55, 0, 0, 0, 0);
    checkVal("mk_pulse_end", MarkerEnable, 0);
    checkVal("mk_stall_count", dut.count, 8);
    cyc(0, 0, 1, 4, 1, 0);
    checkVal("rel_count", dut.count, 0);
    checkVal("rel_hold", MarkerHold, 0);
    checkVal("rel_underflow", Underflow, 0);
    checkVal("rel_read", ByteInRead, 1);
    checkVal("rel_mdata", MarkerData, 8'hD3);

    // underflow
    sendByte(8'h5A);
    checkVal("uf_count8", dut.count, 8);
    cyc(0, 0, 1, 9, 0, 0);
    checkVal("uf_flag", Underflow, 1);
    checkVal("uf_count", dut.count, 0);
    cyc(1, 8'h11, 0, 0, 0, 0);
    checkVal("uf_sticky", Underflow, 1);
    doInit();
    checkVal("uf_clear", Underflow, 0);
    checkVal("init_mdata", MarkerData, 0);

    // buffer full boundary
    for (int i = 1; i <= 7; i++) sendByte(8'(i));
    checkVal("full_read56", ByteInRead, 1);
    sendByte(8'h08);
    checkVal("full_count", dut.count, 64);
    checkVal("full_read64", ByteInRead, 0);
    sendByte(8'hEE);
    checkVal("full_nopush", dut.count, 64);
    checkVal("full_dout", DataOut, 32'h01020304);
    cyc(0, 0, 1, 32, 0, 0);
    checkVal("full_dout2", DataOut, 32'h05060708);
    checkVal("full_read32", ByteInRead, 1);

    // asynchronous reset mid-operation
    sendByte(8'h09);
    checkVal("ar_count40", dut.count, 40);
    #2 rst = 0;
    #1;
    checkVal("ar_dout", DataOut, 0);
    checkVal("ar_outs", {DataOutEnable, ByteInRead, MarkerHold, Underflow}, 0);
    checkVal("ar_count", dut.count, 0);
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    checkVal("ar_read", ByteInRead, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
